// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: funct3 size codes and MEM-stage access FSM state encodings
package mem_access_unit_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: extracts a byte/half/word/double from a bus word and sign/zero extends it
//   rdata  : full bus word
//   off    : byte offset of the access within the word
//   funct3 : [1:0] size, [2] 1=zero-extend
//   data   : aligned, extended result
module mem_load_align #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0]              rdata,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic [2:0]                   funct3,
  output logic [XLEN-1:0]              data
);
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] mask;
  logic            sign;
  always_comb begin
    sh   = rdata >> {off, 3'b000};
    mask = funct3[1:0] == 2'b00 ? XLEN'('hFF) :
           funct3[1:0] == 2'b01 ? XLEN'('hFFFF) :
           funct3[1:0] == 2'b10 ? XLEN'(32'hFFFF_FFFF) : '1;
    sign = ~funct3[2] & (funct3[1:0] == 2'b00 ? sh[7] :
                         funct3[1:0] == 2'b01 ? sh[15] :
                         funct3[1:0] == 2'b10 ? sh[31] : 1'b0);
    // Bits above the access size come from the sign bit (or zero); a full-width word keeps rdata.
    data = (sh & mask) | ({XLEN{sign}} & ~mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data memory access engine on a valid/ready bus
//   valid/mem_read/mem_write/addr/wdata/funct3 : EX/MEM entry
//   hold          : stalls the upstream pipeline while an access is in flight (combinational)
//   bus_req_*     : request channel, driven from latched values in REQ
//   bus_rsp_*     : response channel, accepted in WAIT
//   load_data     : registered load result
//   done/misaligned/access_fault : single-cycle status pulses
module mem_access_unit import mem_access_unit_pkg::*; #(parameter int XLEN = 32) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [XLEN-1:0]     addr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [2:0]          funct3,
  output logic                hold,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [XLEN-1:0]     bus_req_addr,
  output logic                bus_req_we,
  output logic [XLEN-1:0]     bus_req_wdata,
  output logic [XLEN/8-1:0]   bus_req_wstrb,
  input  logic                bus_rsp_valid,
  input  logic [XLEN-1:0]     bus_rsp_rdata,
  input  logic                bus_rsp_err,
  output logic [XLEN-1:0]     load_data,
  output logic                done,
  output logic                misaligned,
  output logic                access_fault
);
  localparam int OW = $clog2(XLEN/8);
  localparam int SW = XLEN/8;
  logic [1:0]      state;
  logic [XLEN-1:0] a_q, d_q, ext;
  logic [2:0]      f_q;
  logic            we_q, op, legal, aligned, start;
  logic [2:0]      amask;
  logic [SW-1:0]   base;
  always_comb begin
    op      = valid & (mem_read | mem_write);
    // Stores only look at the size bits, so 3'b111 on a store is a double.
    legal   = (funct3[1:0] != F3_LD[1:0] || XLEN == 64) & (mem_write | funct3 != 3'b111);
    amask   = funct3[1:0] == F3_LB[1:0] ? 3'd0 : funct3[1:0] == F3_LH[1:0] ? 3'd1 :
              funct3[1:0] == F3_LW[1:0] ? 3'd3 : 3'd7;
    aligned = (addr[2:0] & amask) == 3'd0;
    start   = state == IDLE & op & legal & aligned;
    hold    = start | state == REQ | state == WAIT;
    base    = f_q[1:0] == F3_LB[1:0] ? SW'(1) : f_q[1:0] == F3_LH[1:0] ? SW'(3) :
              f_q[1:0] == F3_LW[1:0] ? SW'(4'hF) : '1;
    bus_req_valid = state == REQ;
    bus_req_we    = we_q;
    bus_req_addr  = {a_q[XLEN-1:OW], OW'(0)};
    bus_req_wstrb = we_q ? base << a_q[OW-1:0] : '0;
    bus_req_wdata = f_q[1:0] == F3_LB[1:0] ? {(XLEN/8){d_q[7:0]}} :
                    f_q[1:0] == F3_LH[1:0] ? {(XLEN/16){d_q[15:0]}} :
                    f_q[1:0] == F3_LW[1:0] ? {(XLEN/32){d_q[31:0]}} : d_q;
  end
  mem_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (bus_rsp_rdata),
    .off    (a_q[OW-1:0]),
    .funct3 (f_q),
    .data   (ext)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      a_q          <= '0;
      d_q          <= '0;
      f_q          <= '0;
      we_q         <= 1'b0;
      load_data    <= '0;
      done         <= 1'b0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
    end else begin
      done         <= state == WAIT & bus_rsp_valid;
      misaligned   <= state == IDLE & op & legal & ~aligned;
      access_fault <= (state == WAIT & bus_rsp_valid & bus_rsp_err) | (state == IDLE & op & ~legal);
      if (start) begin
        state <= REQ;
        a_q   <= addr;
        d_q   <= wdata;
        f_q   <= funct3;
        we_q  <= mem_write;
      end else if (state == REQ && bus_req_ready) begin
        state <= WAIT;
      end else if (state == WAIT && bus_rsp_valid) begin
        state <= DONE;
        if (!bus_rsp_err && !we_q) load_data <= ext;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store accesses checked against a byte-lane model
module tb_mem_access_unit;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  funct3 = '0;
  logic        hold, bus_req_valid, bus_req_we;
  logic        bus_req_ready = 1'b0;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
  logic [31:0] bus_rsp_rdata = '0;
  logic [31:0] load_data;
  logic        done, misaligned, access_fault;
  int          errs = 0, checks = 0;
  logic [31:0] exp_ld = '0;
  always #5 clk = ~clk;
  mem_access_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .funct3(funct3), .hold(hold),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_req_we(bus_req_we), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
    .load_data(load_data), .done(done), .misaligned(misaligned), .access_fault(access_fault)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction
  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = 1 << f3[1:0];
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic err, input int dly);
    valid = 1'b1; mem_read = ~wr; mem_write = wr; funct3 = f3; addr = a; wdata = d;
    #1;
    chk1("start_hold", hold, 1'b1);
    chk1("idle_req_valid", bus_req_valid, 1'b0);
    step;
    for (int i = 0; i <= dly; i++) begin
      chk1("req_valid", bus_req_valid, 1'b1);
      chk("req_addr", bus_req_addr, a & ~32'h3);
      chk1("req_we", bus_req_we, wr);
      chk("req_strb", 32'(bus_req_wstrb), wr ? 32'(ref_strb(f3, a)) : 32'h0);
      if (wr) chk("req_wdata", bus_req_wdata, ref_wdata(f3, d));
      chk1("req_hold", hold, 1'b1);
      bus_req_ready = (i == dly);
      step;
    end
    bus_req_ready = 1'b0;
    chk1("wait_valid", bus_req_valid, 1'b0);
    chk1("wait_hold", hold, 1'b1);
    chk1("wait_done", done, 1'b0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = rd; bus_rsp_err = err;
    step;
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
    if (!wr && !err) exp_ld = ref_load(f3, a, rd);
    chk1("done", done, 1'b1);
    chk1("done_fault", access_fault, err);
    chk1("done_hold", hold, 1'b0);
    chk("load_data", load_data, exp_ld);
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    step;
    chk1("done_clear", done, 1'b0);
    chk1("fault_clear", access_fault, 1'b0);
  endtask
  task automatic bad(input logic [2:0] f3, input logic [31:0] a, input logic exp_mis);
    valid = 1'b1; mem_read = 1'b1; funct3 = f3; addr = a;
    #1;
    chk1("bad_hold", hold, 1'b0);
    chk1("bad_req_valid", bus_req_valid, 1'b0);
    step;
    chk1("bad_misaligned", misaligned, exp_mis);
    chk1("bad_fault", access_fault, ~exp_mis);
    chk1("bad_req_valid2", bus_req_valid, 1'b0);
    chk1("bad_hold2", hold, 1'b0);
    valid = 1'b0; mem_read = 1'b0;
    step;
    chk1("bad_mis_clear", misaligned, 1'b0);
    chk1("bad_fault_clear", access_fault, 1'b0);
    chk1("bad_no_done", done, 1'b0);
  endtask
  initial begin
    step;
    chk1("rst_req_valid", bus_req_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_mis", misaligned, 1'b0);
    chk1("rst_fault", access_fault, 1'b0);
    chk("rst_load_data", load_data, 32'h0);
    chk1("rst_hold", hold, 1'b0);
    reset_n = 1'b1;
    step;
    chk1("idle_noop_hold", hold, 1'b0);
    access(1'b0, 3'b010, 32'h1004, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    chk("lw_const", load_data, 32'hDEADBEEF);
    access(1'b0, 3'b000, 32'h2003, 32'h0, 32'h80112233, 1'b0, 0);
    chk("lb_const", load_data, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h2003, 32'h0, 32'h80112233, 1'b0, 1);
    chk("lbu_const", load_data, 32'h00000080);
    access(1'b0, 3'b001, 32'h2002, 32'h0, 32'h80010000, 1'b0, 0);
    chk("lh_const", load_data, 32'hFFFF8001);
    access(1'b1, 3'b000, 32'h3001, 32'h000000AB, 32'h0, 1'b0, 0);
    chk("sb_keeps_load", load_data, 32'hFFFF8001);
    access(1'b1, 3'b001, 32'h3002, 32'h00001234, 32'h0, 1'b0, 0);
    bad(3'b010, 32'h1002, 1'b1);
    bad(3'b001, 32'h1001, 1'b1);
    bad(3'b011, 32'h1000, 1'b0);
    bad(3'b111, 32'h1000, 1'b0);
    access(1'b0, 3'b010, 32'h5000, 32'h0, 32'h12345678, 1'b1, 5);
    chk("err_keeps_load", load_data, 32'hFFFF8001);
    for (int k = 0; k < 40; k++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      if (f3 == 3'b011) f3 = 3'b110;
      a = $urandom;
      a = a & ~(32'((1 << f3[1:0]) - 1));
      access(wr, f3, a, $urandom, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 2));
    end
    valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h4000;
    step;
    bus_req_ready = 1'b1;
    step;
    bus_req_ready = 1'b0; valid = 1'b0; mem_read = 1'b0;
    chk1("pre_rst_hold", hold, 1'b1);
    reset_n = 1'b0;
    #1;
    exp_ld = '0;
    chk1("async_rst_req_valid", bus_req_valid, 1'b0);
    chk1("async_rst_hold", hold, 1'b0);
    chk("async_rst_load", load_data, exp_ld);
    chk1("async_rst_done", done, 1'b0);
    step;
    reset_n = 1'b1;
    step;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFEF00D;
    step;
    bus_rsp_valid = 1'b0;
    chk1("stale_no_done", done, 1'b0);
    chk1("stale_hold", hold, 1'b0);
    chk("stale_load", load_data, 32'h0);
    step;
    chk1("stale_no_done2", done, 1'b0);
    access(1'b0, 3'b101, 32'h6002, 32'h0, 32'hF00D1234, 1'b0, 0);
    chk("lhu_const", load_data, 32'h0000F00D);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory access engine. It consumes the EX/MEM pipeline outputs (address, store data, funct3, mem_read/mem_write, valid). It issues one request per load/store on a valid/ready data bus and waits for the response. It returns aligned and extended load data. While an access is in flight it drives hold back to the EX/MEM register and the upstream pipeline.

Parameters:
XLEN, 32, data/address width; 32 or 64 only.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
valid  input  1  EX/MEM entry is a valid instruction
mem_read  input  1  entry is a load
mem_write  input  1  entry is a store
addr  input  XLEN  effective address (alu_result)
wdata  input  XLEN  store data, LSB-justified
funct3  input  3  access size/signedness
hold  output  1  stall pipeline; combinational
bus_req_valid  output  1  request valid
bus_req_ready  input  1  bus accepts request
bus_req_addr  output  XLEN  addr with low log2(XLEN/8) bits cleared
bus_req_we  output  1  1=store
bus_req_wdata  output  XLEN  store data replicated into target lanes
bus_req_wstrb  output  XLEN/8  byte enables
bus_rsp_valid  input  1  response valid (1-cycle pulse)
bus_rsp_rdata  input  XLEN  read data, full bus word
bus_rsp_err  input  1  bus error with response
load_data  output  XLEN  extracted/extended load result, registered
done  output  1  1-cycle pulse: access complete
misaligned  output  1  1-cycle pulse: misaligned access, no bus traffic
access_fault  output  1  1-cycle pulse: bus error or illegal size

Behaviour:
- Reset values (async, reset_n=0):
  - Outputs: all registered outputs are 0; bus_req_valid=0, done=0, misaligned=0, access_fault=0, load_data=0.
  - State: state=IDLE.
  - Reset mid-access abandons the access. The bus is reset together with this block.
- start = valid & (mem_read|mem_write) & aligned & legal_size, evaluated in IDLE only.
- Size decode:
  - funct3 000/100 = byte; 001/101 = half; 010 = word; 110 = word unsigned.
  - funct3 011 = double. Legal only when XLEN=64; otherwise illegal size.
  - 111 is illegal.
  - Stores use funct3[1:0] only.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0.
- States:
  - IDLE
    - On start: latch addr/wdata/funct3/we and go to REQ.
    - Misaligned op: pulse misaligned next cycle, stay IDLE, hold=0.
    - Illegal size: pulse access_fault next cycle, stay IDLE, hold=0.
  - REQ
    - bus_req_valid=1, with address, data and strobe stable from latched values.
    - On bus_req_ready=1, go to WAIT.
  - WAIT
    - bus_req_valid=0. Responses are never accepted in the same cycle as request acceptance.
    - On bus_rsp_valid, go to DONE.
      - If err=1: access_fault=1, load_data unchanged.
      - If err=0 and the access is a load: load_data <= extract(rdata).
  - DONE
    - done=1 (access_fault concurrent if error). hold=0.
    - Inputs are ignored this cycle, so the same EX/MEM entry cannot restart.
    - Go to IDLE.
- hold = start (in IDLE) | state==REQ | state==WAIT. Minimum access latency is 3 cycles from start to done (REQ→WAIT→DONE with ready=1 and response one cycle later).
- Store lanes: off = addr[log2(XLEN/8)-1:0].
  - Byte: wstrb = 1<<off, data byte replicated across all lanes.
  - Half: wstrb = 2'b11<<off, data half replicated.
  - Word: wstrb = 4'hF<<off.
  - Double: wstrb = all ones.
- Load extract: shift rdata right by off*8, take the low size bits, then extend.
  - Sign-extend for funct3[2]=0.
  - Zero-extend for funct3[2]=1.
  - RV32 word: extension is a no-op.
- Loads ignore wstrb/wdata on the bus; stores leave load_data unchanged.
- valid=0 or no mem op in IDLE: no action, hold=0, all pulses 0.

Decomposition:
- Shared package/header (config include):
  - funct3 size constants (F3_LB..F3_LWU, F3_LD).
  - mem_access_unit FSM state encodings (IDLE, REQ, WAIT, DONE; 2 bits).
- Sub-module mem_load_align: combinational extraction and sign/zero extension, parameterized by XLEN. It is reusable by the writeback path and the atomic unit.

Test Plan:
- LW addr=0x1004, rsp rdata=0xDEADBEEF, ready immediate -> bus_req_addr=0x1004, wstrb=0, hold high 3 cycles, done pulse, load_data=0xDEADBEEF.
- LB addr=0x2003, rdata=0x80112233 -> load_data=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x2002, rdata=0x8001_0000 -> 0xFFFF8001.
- SB addr=0x3001, wdata=0x000000AB -> wstrb=4'b0010, wdata=0xABABABAB, we=1. SH addr=0x3002 -> wstrb=4'b1100.
- LW addr=0x1002 -> misaligned pulse, bus_req_valid never asserted, hold=0. funct3=011 with XLEN=32 -> access_fault pulse, no request.
- bus_req_ready held 0 for 5 cycles -> bus_req_valid and addr stable, hold high throughout. Response with err=1 -> done and access_fault together, load_data unchanged.
- reset_n dropped in WAIT -> outputs 0 immediately, state IDLE. A stale response after reset is ignored and no done pulse occurs.
